// File: rtl/jk_excite_seq.sv
// jk_excite_seq: accepts a target word, drives one cycle of J/K excitation into a
// master-slave JK bank, then checks the fed-back Q and retries up to MAX_RETRY times.
module jk_excite_seq #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MAX_RETRY  = 3,
    parameter bit          USE_TOGGLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);
    localparam int unsigned   CW        = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [CW-1:0] RETRY_LIM = CW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic [WIDTH-1:0] err_mask_q, err_mask_d;
    logic [CW-1:0]    retry_q, retry_d;
    logic             done_q, done_d, err_q, err_d;

    logic [WIDTH-1:0] exc_tgt, diff, exc_j, exc_k;

    // The incoming word is the reference at accept; the latched word on retries.
    always_comb begin
        exc_tgt = (state_q == IDLE) ? tgt_data : tgt_q;
        diff    = q_fb ^ exc_tgt;
        if (USE_TOGGLE) begin
            exc_j = diff;
            exc_k = diff;
        end else begin
            exc_j = diff & exc_tgt;
            exc_k = diff & ~exc_tgt;
        end
    end

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        retry_d    = retry_q;
        j_d        = '0;
        k_d        = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_mask_d = err_mask_q;
        unique case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    retry_d = '0;
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < RETRY_LIM) begin
                    retry_d = retry_q + CW'(1);
                    j_d     = exc_j;
                    k_d     = exc_k;
                    state_d = DRIVE;
                end else begin
                    err_d      = 1'b1;
                    err_mask_d = q_fb ^ tgt_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            retry_q    <= '0;
            j_q        <= '0;
            k_q        <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            retry_q    <= retry_d;
            j_q        <= j_d;
            k_q        <= k_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_mask_q <= err_mask_d;
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign j         = j_q;
    assign k         = k_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_mask  = err_mask_q;
endmodule

// File: tb/tb_jk_excite_seq.sv
// Bench for jk_excite_seq: two instances (toggle and set/reset excitation) each
// driving a behavioural master-slave JK bank; expectations come from a target-level model.
module tb_jk_excite_seq;
    localparam int W  = 4;
    localparam int MR = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         va = 1'b0, vb = 1'b0;
    logic [W-1:0] da = '0, db = '0;
    logic         ra, ba, dna, ea, rb, bb, dnb, eb;
    logic [W-1:0] ja, ka, ma, jb, kb, mb;
    logic [W-1:0] qa = '0, qb = '0, mst_a = '0, mst_b = '0;
    logic [W-1:0] stuck0 = '0, pre_a = '0, pre_b = '0;
    logic         preset_en = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] ref_q = '0, ref_qb = '0, ref_mask = '0;

    jk_excite_seq #(.WIDTH(W), .MAX_RETRY(MR), .USE_TOGGLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .tgt_valid(va), .tgt_data(da), .tgt_ready(ra),
        .j(ja), .k(ka), .q_fb(qa), .busy(ba), .done(dna), .err(ea), .err_mask(ma));

    jk_excite_seq #(.WIDTH(W), .MAX_RETRY(MR), .USE_TOGGLE(1'b0)) dut_sr (
        .clk(clk), .rst_n(rst_n), .tgt_valid(vb), .tgt_data(db), .tgt_ready(rb),
        .j(jb), .k(kb), .q_fb(qb), .busy(bb), .done(dnb), .err(eb), .err_mask(mb));

    // Master samples J/K on the rising edge, slave Q follows on the falling edge.
    always @(posedge clk) begin
        mst_a <= (ja & ~qa) | (~ka & qa);
        mst_b <= (jb & ~qb) | (~kb & qb);
    end
    always @(negedge clk) begin
        qa <= preset_en ? pre_a : (mst_a & ~stuck0);
        qb <= preset_en ? pre_b : mst_b;
    end

    function automatic logic [2*W-1:0] excite(input logic [W-1:0] q, input logic [W-1:0] t,
                                              input bit tog);
        logic [W-1:0] jj, kk;
        jj = '0;
        kk = '0;
        for (int i = 0; i < W; i++) begin
            if (q[i] != t[i]) begin
                jj[i] = tog ? 1'b1 : t[i];
                kk[i] = tog ? 1'b1 : ~t[i];
            end
        end
        return {jj, kk};
    endfunction

    task automatic preset(input logic [W-1:0] a, input logic [W-1:0] b);
        pre_a = a;
        pre_b = b;
        preset_en = 1'b1;
        @(negedge clk); #1;
        preset_en = 1'b0;
        ref_q  = a;
        ref_qb = b;
        @(posedge clk); #1;
    endtask

    task automatic drive_op(input logic [W-1:0] t, input string tag);
        logic [W-1:0]   qm;
        logic [2*W-1:0] e;
        qm = ref_q;
        checks++;
        if ({ra, ba} !== 2'b10) begin
            failures++;
            $display("FAIL %s_idle ready/busy act=%b exp=10", tag, {ra, ba});
        end
        va = 1'b1;
        da = t;
        @(posedge clk); #1;
        va = 1'b0;
        da = W'($urandom);
        for (int a = 0; a <= MR; a++) begin
            e = excite(qm, t, 1'b1);
            checks++;
            if ({ja, ka, ra, ba, dna, ea, ma} !== {e, 4'b0100, ref_mask}) begin
                failures++;
                $display("FAIL %s_drive%0d act=%h exp=%h", tag, a,
                         {ja, ka, ra, ba, dna, ea, ma}, {e, 4'b0100, ref_mask});
            end
            @(posedge clk); #1;
            checks++;
            if ({ja, ka, ra, ba, dna, ea, ma} !== {{(2*W){1'b0}}, 4'b0100, ref_mask}) begin
                failures++;
                $display("FAIL %s_check%0d act=%h exp=%h", tag, a,
                         {ja, ka, ra, ba, dna, ea, ma}, {{(2*W){1'b0}}, 4'b0100, ref_mask});
            end
            qm = t & ~stuck0;
            @(posedge clk); #1;
            if (qm == t) begin
                checks++;
                if ({ja, ka, ra, ba, dna, ea, ma, qa} !== {{(2*W){1'b0}}, 4'b1010, ref_mask, t}) begin
                    failures++;
                    $display("FAIL %s_done act=%h exp=%h", tag, {ja, ka, ra, ba, dna, ea, ma, qa},
                             {{(2*W){1'b0}}, 4'b1010, ref_mask, t});
                end
                break;
            end else if (a == MR) begin
                ref_mask = qm ^ t;
                checks++;
                if ({ja, ka, ra, ba, dna, ea, ma} !== {{(2*W){1'b0}}, 4'b1001, ref_mask}) begin
                    failures++;
                    $display("FAIL %s_err act=%h exp=%h", tag, {ja, ka, ra, ba, dna, ea, ma},
                             {{(2*W){1'b0}}, 4'b1001, ref_mask});
                end
            end
        end
        ref_q = qm;
        @(posedge clk); #1;
        checks++;
        if ({ra, ba, dna, ea, ma} !== {4'b1000, ref_mask}) begin
            failures++;
            $display("FAIL %s_pulse_end act=%h exp=%h", tag, {ra, ba, dna, ea, ma}, {4'b1000, ref_mask});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ja, ka, ra, ba, dna, ea, ma, jb, kb, rb, bb, dnb, eb, mb} !==
            {{(2*W){1'b0}}, 4'b1000, {W{1'b0}}, {(2*W){1'b0}}, 4'b1000, {W{1'b0}}}) begin
            failures++;
            $display("FAIL reset_values act=%h", {ja, ka, ra, ba, dna, ea, ma, jb, kb, rb, bb, dnb, eb, mb});
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_toggle();
        preset(4'b0000, 4'b0000);
        drive_op(4'b1010, "toggle_1010");
    endtask

    task automatic test_equal();
        preset(4'b0101, 4'b0000);
        drive_op(4'b0101, "equal_0101");
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) drive_op(W'($urandom), "random");
    endtask

    task automatic test_setreset();
        logic [W-1:0]   t;
        logic [2*W-1:0] e;
        preset(ref_q, 4'b1100);
        for (int n = 0; n < 6; n++) begin
            t = (n == 0) ? 4'b0110 : W'($urandom);
            vb = 1'b1;
            db = t;
            @(posedge clk); #1;
            vb = 1'b0;
            db = W'($urandom);
            e = excite(ref_qb, t, 1'b0);
            checks++;
            if ({jb, kb, rb, bb, dnb, eb} !== {e, 4'b0100}) begin
                failures++;
                $display("FAIL setreset_drive%0d act=%h exp=%h", n, {jb, kb, rb, bb, dnb, eb}, {e, 4'b0100});
            end
            @(posedge clk); #1;
            checks++;
            if ({jb, kb, rb, bb, dnb, eb} !== {{(2*W){1'b0}}, 4'b0100}) begin
                failures++;
                $display("FAIL setreset_check%0d act=%h", n, {jb, kb, rb, bb, dnb, eb});
            end
            @(posedge clk); #1;
            checks++;
            if ({rb, bb, dnb, eb, qb} !== {4'b1010, t}) begin
                failures++;
                $display("FAIL setreset_done%0d act=%h exp=%h", n, {rb, bb, dnb, eb, qb}, {4'b1010, t});
            end
            ref_qb = t;
            @(posedge clk); #1;
            checks++;
            if ({rb, bb, dnb, eb} !== 4'b1000) begin
                failures++;
                $display("FAIL setreset_pulse%0d act=%b exp=1000", n, {rb, bb, dnb, eb});
            end
        end
    endtask

    task automatic test_stuck();
        preset(4'b0000, ref_qb);
        stuck0 = 4'b0001;
        drive_op(4'b0001, "stuck_bit0");
        stuck0 = 4'b0000;
        checks++;
        if (ma !== 4'b0001) begin
            failures++;
            $display("FAIL stuck_mask_hold act=%b exp=0001", ma);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]   t;
        logic [2*W-1:0] e;
        t = 4'b1111;
        va = 1'b1;
        da = t;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if ({ra, ba} !== 2'b10) begin
                failures++;
                $display("FAIL b2b_ready%0d act=%b exp=10", n, {ra, ba});
            end
            @(posedge clk); #1;
            e = excite(ref_q, t, 1'b1);
            da = W'($urandom);
            checks++;
            if ({ja, ka, ra, ba, dna, ea} !== {e, 4'b0100}) begin
                failures++;
                $display("FAIL b2b_drive%0d act=%h exp=%h", n, {ja, ka, ra, ba, dna, ea}, {e, 4'b0100});
            end
            @(posedge clk); #1;
            da = W'($urandom);
            checks++;
            if ({ja, ka, ra, ba, dna, ea} !== {{(2*W){1'b0}}, 4'b0100}) begin
                failures++;
                $display("FAIL b2b_check%0d act=%h", n, {ja, ka, ra, ba, dna, ea});
            end
            @(posedge clk); #1;
            checks++;
            if ({ra, ba, dna, ea, qa} !== {4'b1010, t}) begin
                failures++;
                $display("FAIL b2b_done%0d act=%h exp=%h", n, {ra, ba, dna, ea, qa}, {4'b1010, t});
            end
            ref_q = t;
            t = ~t;
            da = t;
            if (n == 3) va = 1'b0;
        end
        @(posedge clk); #1;
        checks++;
        if ({ra, ba, dna, ea} !== 4'b1000) begin
            failures++;
            $display("FAIL b2b_final act=%b exp=1000", {ra, ba, dna, ea});
        end
    endtask

    task automatic test_reset_mid();
        preset(4'b0000, ref_qb);
        va = 1'b1;
        da = 4'b1111;
        @(posedge clk); #1;
        va = 1'b0;
        checks++;
        if ({ja, ka, ba} !== {8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL midrst_drive act=%h exp=1ff", {ja, ka, ba});
        end
        rst_n = 1'b0;
        #1;
        ref_mask = '0;
        checks++;
        if ({ja, ka, ra, ba, dna, ea, ma} !== {{(2*W){1'b0}}, 4'b1000, {W{1'b0}}}) begin
            failures++;
            $display("FAIL midrst_async act=%h", {ja, ka, ra, ba, dna, ea, ma});
        end
        @(posedge clk); #1;
        checks++;
        if ({ja, ka, ra, ba, dna, ea, qa} !== {{(2*W){1'b0}}, 4'b1000, 4'b0000}) begin
            failures++;
            $display("FAIL midrst_held act=%h", {ja, ka, ra, ba, dna, ea, qa});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        drive_op(4'b1111, "after_reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_toggle();
        test_equal();
        test_setreset();
        test_random();
        test_stuck();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jk_excite_seq.md
# jk_excite_seq

Sequencer that drives a bank of master-slave JK flip-flops to a requested target value. It accepts target words over a valid/ready handshake and computes per-bit J/K excitation from the bank's fed-back Q. It drives the excitation for exactly one clock, then verifies the bank's output and retries on mismatch. It sits between control logic, which thinks in target values, and a register bank built from master-slave JK cells, which sample J/K on the rising clock edge and update Q on the falling edge.

## Interface
- `WIDTH`, default 4: number of JK cells driven (1..32).
- `MAX_RETRY`, default 3: drive attempts allowed after the first before reporting an error (0..15).
- `USE_TOGGLE`, default 1:
  - 1: bits that must change get J=K=1 (toggle).
  - 0: bits that must change get set (J=1,K=0) or reset (J=0,K=1) toward the target.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tgt_valid` in 1: target word offered.
- `tgt_data` in WIDTH: requested bank value.
- `tgt_ready` out 1: block idle and able to accept.
- `j` out WIDTH: J excitation to bank, registered.
- `k` out WIDTH: K excitation to bank, registered.
- `q_fb` in WIDTH: Q outputs of the bank.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse, bank verified equal to target.
- `err` out 1: one-cycle pulse, retries exhausted.
- `err_mask` out WIDTH: bits of q_fb that differed from target at the failing check; holds its value until the next err or reset.

## Operation
- States: IDLE, DRIVE, CHECK.
- IDLE:
  - `tgt_ready`=1 and `j`=`k`=0.
  - Accept on rising edge with `tgt_valid`&&`tgt_ready`: latch `tgt_data` into `tgt_q`, clear the retry counter, load excitation from `q_fb` vs `tgt_data`, go to DRIVE.
- Excitation per bit i:
  - q_fb[i]==tgt[i]: J=K=0 (hold).
  - Otherwise, with USE_TOGGLE=1: J=K=1.
  - Otherwise, with USE_TOGGLE=0: J=tgt[i], K=~tgt[i].
- DRIVE (one cycle): `j`/`k` hold the loaded excitation. At the next edge the block clears `j`/`k` to 0 and goes to CHECK.
- CHECK (one cycle): at the next edge the block compares `q_fb` with `tgt_q`.
  - Equal: pulse `done`, go to IDLE.
  - Unequal and retry count < MAX_RETRY: increment the count, reload excitation from the current `q_fb`, go to DRIVE.
  - Unequal and retry count == MAX_RETRY: pulse `err`, load `err_mask` = q_fb ^ tgt_q, go to IDLE.
- A target equal to the current `q_fb` still passes through DRIVE (all-zero excitation) and CHECK, then reports `done`.
- `tgt_valid` is ignored while `busy`. `tgt_data` is sampled only at the accept edge.
- `busy` = (state != IDLE). `tgt_ready` = (state == IDLE).
- The retry counter is ceil(log2(MAX_RETRY+1)) bits and saturates (never wraps).

## Timing
- Accept edge E0 loads `j`/`k`.
- The bank master samples them at E1; the block clears `j`/`k` at E1.
- The bank Q settles at the falling edge after E1.
- CHECK compares at E2. `done`/`err` are high from E2 to E3 and `tgt_ready` returns high from E2.
- Minimum accept-to-done latency: 2 cycles.
- Each retry adds 2 cycles. Worst case is 2*(MAX_RETRY+1) cycles.
- Back-to-back operation: a new accept is possible at E3 when `tgt_valid` is held, giving a throughput of one target per 3 cycles.
- `done` and `err` are never high in the same cycle, and never for more than one cycle.
- Reset values (asynchronous, on `rst_n`=0):
  - state IDLE, `j`=`k`=0, `tgt_ready`=1.
  - `busy`=`done`=`err`=0, `err_mask`=0, retry counter 0.
- Reset mid-operation (DRIVE or CHECK): `j`/`k` drop to 0 immediately, with no pulse on `done` or `err`. The first accept is possible at the first rising edge after `rst_n` rises.

## Test plan
- WIDTH=4, USE_TOGGLE=1, behavioural master-slave JK bank starting at 0000; offer 1010 -> `j`=`k`=1010 for one cycle, then `done` at E2, `q_fb`=1010.
- USE_TOGGLE=0, bank at 1100; offer 0110 -> `j`=0010, `k`=1000 for one cycle, then `done` at E2, `q_fb`=0110.
- Offer a target equal to the current bank value 0101 -> `j`=`k`=0000 throughout, `done` at E2.
- Bank bit 0 forced stuck at 0, MAX_RETRY=3; offer 0001 -> four DRIVE phases, `err` at E8, `err_mask`=0001, no `done`.
- Hold `tgt_valid` high with alternating targets 1111/0000 -> accepts every 3 cycles; `tgt_ready` is low during DRIVE/CHECK, and data changes while busy are ignored.
- Assert `rst_n`=0 during DRIVE with `j`=1111 -> `j`/`k` are 0 immediately, `tgt_ready`=1, no `done`/`err`; the next offer after reset completes normally.
